// File: rtl/i3c_phy_pkg.sv
// Shared types for the I3C/I2C physical-layer receive path.
// Bundles SCL/SDA per-line signals and the decoded bus conditions.
package i3c_phy_pkg;

    localparam int unsigned CNT_WIDTH_DEFAULT = 8;

    typedef struct packed {
        logic scl;
        logic sda;
    } bus_line_t;

    typedef struct packed {
        logic start;
        logic rstart;
        logic stop;
    } bus_cond_t;

endpackage : i3c_phy_pkg

// File: rtl/line_glitch_filter.sv
// One bus line: two-flop synchronizer, run-length glitch filter and filtered
// edge pulses. Reset assumes an idle (high) line.
module line_glitch_filter #(
    parameter int unsigned CntWidth = 8
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                line_i,
    input  logic [CntWidth-1:0] t_glitch_i,
    output logic                level_o,
    output logic                posedge_o,
    output logic                negedge_o
);

    logic                sync_q1;
    logic                sync_q2;
    logic                filt_q;
    logic                filt_prev_q;
    logic [CntWidth-1:0] cnt_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            sync_q1     <= 1'b1;
            sync_q2     <= 1'b1;
            filt_q      <= 1'b1;
            filt_prev_q <= 1'b1;
            cnt_q       <= '0;
        end else begin
            sync_q1     <= line_i;
            sync_q2     <= sync_q1;
            filt_prev_q <= filt_q;
            if (sync_q2 == filt_q) begin
                cnt_q <= '0;
            end else if (cnt_q >= t_glitch_i) begin
                // The run has outlasted the threshold: commit the new level.
                filt_q <= sync_q2;
                cnt_q  <= '0;
            end else if (cnt_q != '1) begin
                cnt_q <= cnt_q + 1'b1;
            end
        end
    end

    assign level_o   = filt_q;
    assign posedge_o = filt_q & ~filt_prev_q;
    assign negedge_o = ~filt_q & filt_prev_q;

endmodule : line_glitch_filter

// File: rtl/bus_line_receiver.sv
// Receive front end for SCL/SDA: filtered levels, edge pulses, and
// START / repeated START / STOP detection with a bus-busy flag.
module bus_line_receiver
    import i3c_phy_pkg::*;
#(
    parameter int unsigned CntWidth = CNT_WIDTH_DEFAULT
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                scl_i,
    input  logic                sda_i,
    input  logic [CntWidth-1:0] t_glitch_i,
    output logic                scl_o,
    output logic                sda_o,
    output logic                scl_posedge_o,
    output logic                scl_negedge_o,
    output logic                sda_posedge_o,
    output logic                sda_negedge_o,
    output logic                start_det_o,
    output logic                rstart_det_o,
    output logic                stop_det_o,
    output logic                bus_busy_o
);

    bus_line_t level;
    bus_line_t rise;
    bus_line_t fall;
    bus_cond_t cond;
    logic      scl_held_high;
    logic      bus_busy_q;

    line_glitch_filter #(.CntWidth(CntWidth)) u_scl_filter (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .line_i     (scl_i),
        .t_glitch_i (t_glitch_i),
        .level_o    (level.scl),
        .posedge_o  (rise.scl),
        .negedge_o  (fall.scl)
    );

    line_glitch_filter #(.CntWidth(CntWidth)) u_sda_filter (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .line_i     (sda_i),
        .t_glitch_i (t_glitch_i),
        .level_o    (level.sda),
        .posedge_o  (rise.sda),
        .negedge_o  (fall.sda)
    );

    // SCL high now and in the previous cycle; a rising edge implies it was low.
    assign scl_held_high = level.scl & ~rise.scl;

    always_comb begin
        cond        = '0;
        cond.start  = fall.sda & scl_held_high & ~bus_busy_q;
        cond.rstart = fall.sda & scl_held_high &  bus_busy_q;
        cond.stop   = rise.sda & scl_held_high;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            bus_busy_q <= 1'b0;
        end else if (cond.start || cond.rstart) begin
            bus_busy_q <= 1'b1;
        end else if (cond.stop) begin
            bus_busy_q <= 1'b0;
        end
    end

    assign scl_o         = level.scl;
    assign sda_o         = level.sda;
    assign scl_posedge_o = rise.scl;
    assign scl_negedge_o = fall.scl;
    assign sda_posedge_o = rise.sda;
    assign sda_negedge_o = fall.sda;
    assign start_det_o   = cond.start;
    assign rstart_det_o  = cond.rstart;
    assign stop_det_o    = cond.stop;
    assign bus_busy_o    = bus_busy_q;

endmodule : bus_line_receiver

// File: tb/tb_bus_line_receiver.sv
// Directed bench for bus_line_receiver: filter thresholds, edge timing,
// START / repeated START / STOP decoding and reset behaviour.
module tb_bus_line_receiver;

    logic       clk;
    logic       rst;
    logic       scl;
    logic       sda;
    logic [7:0] t_glitch;
    logic       scl_o;
    logic       sda_o;
    logic       scl_posedge_o;
    logic       scl_negedge_o;
    logic       sda_posedge_o;
    logic       sda_negedge_o;
    logic       start_det_o;
    logic       rstart_det_o;
    logic       stop_det_o;
    logic       bus_busy_o;

    int checks = 0;
    int errors = 0;

    bus_line_receiver #(.CntWidth(8)) dut (
        .clk_i         (clk),
        .rst_i         (rst),
        .scl_i         (scl),
        .sda_i         (sda),
        .t_glitch_i    (t_glitch),
        .scl_o         (scl_o),
        .sda_o         (sda_o),
        .scl_posedge_o (scl_posedge_o),
        .scl_negedge_o (scl_negedge_o),
        .sda_posedge_o (sda_posedge_o),
        .sda_negedge_o (sda_negedge_o),
        .start_det_o   (start_det_o),
        .rstart_det_o  (rstart_det_o),
        .stop_det_o    (stop_det_o),
        .bus_busy_o    (bus_busy_o)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask

    // {scl_o, sda_o, scl_pe, scl_ne, sda_pe, sda_ne, start, rstart, stop, busy}
    function automatic logic [9:0] all_out();
        return {scl_o, sda_o, scl_posedge_o, scl_negedge_o, sda_posedge_o,
                sda_negedge_o, start_det_o, rstart_det_o, stop_det_o, bus_busy_o};
    endfunction

    initial begin
        rst      = 1'b1;
        scl      = 1'b1;
        sda      = 1'b1;
        t_glitch = 8'd4;
        ticks(3);
        check_eq("reset_state", all_out(), 10'b11_0000_0000);
        rst = 1'b0;

        // idle bus, t_glitch = 4
        for (int i = 0; i < 50; i++) begin
            tick();
            check_eq("idle", all_out(), 10'b11_0000_0000);
        end

        // 4-cycle SDA glitch is rejected
        sda = 1'b0;
        for (int i = 1; i <= 16; i++) begin
            tick();
            if (i == 4) sda = 1'b1;
            check_eq("glitch4", {sda_o, sda_negedge_o, start_det_o}, 3'b100);
        end

        // 6-cycle SDA low: falls at 7 (START), recovers at 13 (STOP)
        sda = 1'b0;
        for (int i = 1; i <= 15; i++) begin
            tick();
            if (i == 6) sda = 1'b1;
            check_eq("run6_neg", sda_negedge_o, (i == 7) ? 1 : 0);
            check_eq("run6_start", start_det_o, (i == 7) ? 1 : 0);
            check_eq("run6_stop", stop_det_o, (i == 13) ? 1 : 0);
            if (i == 7)  check_eq("run6_low", sda_o, 1'b0);
            if (i == 8)  check_eq("run6_busy", bus_busy_o, 1'b1);
            if (i == 14) check_eq("run6_idle", bus_busy_o, 1'b0);
        end

        // t_glitch = 0: START, repeated START, STOP
        t_glitch = 8'd0;
        ticks(5);
        sda = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            tick();
            check_eq("start0", start_det_o, (i == 3) ? 1 : 0);
            check_eq("start0_sda", sda_o, (i >= 3) ? 0 : 1);
        end
        check_eq("start0_busy", bus_busy_o, 1'b1);
        scl = 1'b0;
        ticks(5);
        sda = 1'b1;
        ticks(5);
        check_eq("data_rise_no_stop_busy", bus_busy_o, 1'b1);
        scl = 1'b1;
        ticks(5);
        sda = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            tick();
            check_eq("rstart", rstart_det_o, (i == 3) ? 1 : 0);
            check_eq("rstart_no_start", start_det_o, 1'b0);
        end
        check_eq("rstart_busy", bus_busy_o, 1'b1);
        sda = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            tick();
            check_eq("stop", stop_det_o, (i == 3) ? 1 : 0);
            check_eq("stop_pos", sda_posedge_o, (i == 3) ? 1 : 0);
        end
        check_eq("stop_idle", bus_busy_o, 1'b0);

        // simultaneous SCL/SDA fall: edges but no START
        ticks(3);
        scl = 1'b0;
        sda = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            tick();
            check_eq("simul_edges", {scl_negedge_o, sda_negedge_o}, (i == 3) ? 2'b11 : 2'b00);
            check_eq("simul_nostart", {start_det_o, rstart_det_o}, 2'b00);
        end
        check_eq("simul_busy", bus_busy_o, 1'b0);
        scl = 1'b1;
        sda = 1'b1;
        for (int i = 1; i <= 5; i++) begin
            tick();
            check_eq("simul_nostop", stop_det_o, 1'b0);
        end

        // reset while busy, then START seen as a fresh start
        sda = 1'b0;
        ticks(5);
        check_eq("pre_rst_busy", bus_busy_o, 1'b1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check_eq("rst_clears_busy", bus_busy_o, 1'b0);
        check_eq("rst_sda_high", sda_o, 1'b1);
        for (int i = 1; i <= 4; i++) begin
            tick();
            check_eq("post_rst_start", start_det_o, (i == 3) ? 1 : 0);
            check_eq("post_rst_rstart", rstart_det_o, 1'b0);
            check_eq("post_rst_no_rise", sda_posedge_o, 1'b0);
        end
        check_eq("post_rst_busy", bus_busy_o, 1'b1);
        sda = 1'b1;
        ticks(5);
        check_eq("post_rst_stop", bus_busy_o, 1'b0);

        // t_glitch = 255, SDA held low for 300 cycles
        t_glitch = 8'd255;
        ticks(3);
        sda = 1'b0;
        for (int i = 1; i <= 300; i++) begin
            tick();
            if (i == 257) check_eq("sat_still_high", sda_o, 1'b1);
            if (i == 258) begin
                check_eq("sat_fall", sda_o, 1'b0);
                check_eq("sat_neg", sda_negedge_o, 1'b1);
                check_eq("sat_start", start_det_o, 1'b1);
            end
            if (i > 258) check_eq("sat_stays_low", sda_o, 1'b0);
        end
        sda = 1'b1;
        for (int i = 1; i <= 260; i++) begin
            tick();
            if (i == 258) check_eq("sat_stop", stop_det_o, 1'b1);
        end
        check_eq("sat_idle", bus_busy_o, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_bus_line_receiver
